// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared definitions for the sequenced reset synchroniser.
//   - rst_seq_state_e : sequencer FSM state encoding
//   - cnt_width()     : width of the shared hold/gap counter
package rst_seq_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHold = 2'd1,
        StRel  = 2'd2,
        StDone = 2'd3
    } rst_seq_state_e;

    // Counter must hold the larger of the two intervals.
    function automatic int unsigned cnt_width(input int unsigned hold_cycles,
                                              input int unsigned gap_cycles);
        int unsigned max_v;
        max_v = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
        return $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/rst_sync_chain.sv
// rst_sync_chain: asynchronous-assert, synchronous-release reset synchroniser.
// Ports:
//   CLK      in  destination clock
//   RST      in  asynchronous active-low reset
//   SYNC_OUT out last chain stage; high STAGES_NUM edges after RST deasserts
module rst_sync_chain #(
    parameter int unsigned STAGES_NUM = 2
) (
    input  logic CLK,
    input  logic RST,
    output logic SYNC_OUT
);

    logic [STAGES_NUM-1:0] r_chain;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES_NUM-2:0], 1'b1};
        end
    end

    assign SYNC_OUT = r_chain[STAGES_NUM-1];

endmodule

// File: rtl/rst_seq_sync.sv
// rst_seq_sync: synchronises an async active-low reset, stretches it by HOLD_CYCLES,
// then releases NUM_CH active-low channel resets in order (ch0 first), GAP_CYCLES apart.
// A synchronous software reset request restarts the sequence from the hold phase.
// Ports:
//   CLK      in   domain clock
//   RST      in   asynchronous active-low reset
//   SW_RST   in   synchronous active-high software reset request
//   SYNC_RST out  [NUM_CH] active-low channel resets, released in index order
//   RST_DONE out  high once every channel is released
// Build option: RST_SEQ_SWRST_FILT_EN -- SW_RST must be high on two consecutive edges.
module rst_seq_sync
    import rst_seq_pkg::*;
#(
    parameter int unsigned STAGES_NUM  = 2,
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned GAP_CYCLES  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SW_RST,
    output logic [NUM_CH-1:0] SYNC_RST,
    output logic              RST_DONE
);

    localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);
    localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] CH0_ONLY  = NUM_CH'(1);

    logic w_rst_s;
    logic w_sw_trig;

    rst_seq_state_e    r_state,    w_state_d;
    logic [CNT_W-1:0]  r_cnt,      w_cnt_d;
    logic [IDX_W-1:0]  r_idx,      w_idx_d;
    logic [NUM_CH-1:0] r_sync_rst, w_sync_rst_d;
    logic              r_done,     w_done_d;

    rst_sync_chain #(
        .STAGES_NUM (STAGES_NUM)
    ) u_sync_chain (
        .CLK      (CLK),
        .RST      (RST),
        .SYNC_OUT (w_rst_s)
    );

`ifdef RST_SEQ_SWRST_FILT_EN
    logic r_sw_prev;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sw_prev <= 1'b0;
        end else begin
            r_sw_prev <= SW_RST;
        end
    end

    assign w_sw_trig = SW_RST & r_sw_prev;
`else
    assign w_sw_trig = SW_RST;
`endif

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_idx_d      = r_idx;
        w_sync_rst_d = r_sync_rst;
        w_done_d     = r_done;

        if ((r_state != StIdle) && w_sw_trig) begin
            w_state_d    = StHold;
            w_cnt_d      = '0;
            w_idx_d      = '0;
            w_sync_rst_d = '0;
            w_done_d     = 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    // rst_s went high one edge earlier; the edge that observes it
                    // already counts as the first hold cycle.
                    if (w_rst_s) begin
                        if (HOLD_CYCLES == 1) begin
                            w_state_d    = StRel;
                            w_cnt_d      = '0;
                            w_idx_d      = '0;
                            w_sync_rst_d = CH0_ONLY;
                        end else begin
                            w_state_d = StHold;
                            w_cnt_d   = CNT_W'(1);
                        end
                    end
                end
                StHold: begin
                    if (r_cnt == HOLD_LAST) begin
                        w_state_d    = StRel;
                        w_cnt_d      = '0;
                        w_idx_d      = '0;
                        w_sync_rst_d = CH0_ONLY;
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
                StRel: begin
                    // r_idx is the most recently released channel.
                    if (r_idx == IDX_LAST) begin
                        w_state_d = StDone;
                        w_cnt_d   = '0;
                        w_done_d  = 1'b1;
                    end else if (r_cnt == GAP_LAST) begin
                        w_cnt_d      = '0;
                        w_idx_d      = r_idx + 1'b1;
                        w_sync_rst_d = (r_sync_rst << 1) | CH0_ONLY;
                    end else begin
                        w_cnt_d = r_cnt + 1'b1;
                    end
                end
                StDone: begin
                end
                default: begin
                    w_state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_sync_rst <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_idx      <= w_idx_d;
            r_sync_rst <= w_sync_rst_d;
            r_done     <= w_done_d;
        end
    end

    assign SYNC_RST = r_sync_rst;
    assign RST_DONE = r_done;

endmodule

// File: tb/tb_rst_seq_sync.sv
// tb_rst_seq_sync: directed, table-driven bench for rst_seq_sync at default parameters.
// Edge numbering: edge 1 is the first rising edge with RST high after a reset.
module tb_rst_seq_sync;

    logic       CLK = 1'b0;
    logic       RST;
    logic       SW_RST;
    logic [2:0] SYNC_RST;
    logic       RST_DONE;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    typedef struct {
        int         edge_no;
        logic       sw;
        logic [2:0] exp_rst;
        logic       exp_done;
    } vec_t;

    vec_t vecs[$];

    always #5 CLK = ~CLK;

    rst_seq_sync dut (
        .CLK      (CLK),
        .RST      (RST),
        .SW_RST   (SW_RST),
        .SYNC_RST (SYNC_RST),
        .RST_DONE (RST_DONE)
    );

    task automatic step();
        @(posedge CLK);
        #1;
        edge_n++;
    endtask

    task automatic check(input string name, input logic [2:0] e_rst, input logic e_done);
        checks++;
        if (SYNC_RST !== e_rst || RST_DONE !== e_done) begin
            failures++;
            $display("FAIL %s: got SYNC_RST=%b RST_DONE=%b, want SYNC_RST=%b RST_DONE=%b",
                     name, SYNC_RST, RST_DONE, e_rst, e_done);
        end
    endtask

    task automatic add(input int e, input logic sw, input logic [2:0] r, input logic d);
        vec_t v;
        v.edge_no  = e;
        v.sw       = sw;
        v.exp_rst  = r;
        v.exp_done = d;
        vecs.push_back(v);
    endtask

    // Each record: SW_RST value sampled at edge edge_no, outputs expected just after it.
    task automatic run_vecs(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) begin
            while (edge_n < vecs[k].edge_no - 1) step();
            SW_RST = vecs[k].sw;
            step();
            SW_RST = 1'b0;
            check($sformatf("edge%0d", vecs[k].edge_no), vecs[k].exp_rst, vecs[k].exp_done);
        end
    endtask

    task automatic apply_reset(input logic sw_during);
        RST    = 1'b0;
        SW_RST = sw_during;
        #1;
        check("reset_async", 3'b000, 1'b0);
        repeat (5) @(posedge CLK);
        #1;
        check("reset_held", 3'b000, 1'b0);
        RST    = 1'b1;
        edge_n = 0;
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p_lo, p_hi, a_lo, a_hi, r_lo, r_hi, b_lo, b_hi, c_lo, c_hi;
        RST    = 1'b0;
        SW_RST = 1'b0;

        // Power-on sequence followed by software reset from DONE.
        p_lo = vecs.size();
        add(1,  1'b0, 3'b000, 1'b0);
        add(2,  1'b0, 3'b000, 1'b0);
        add(17, 1'b0, 3'b000, 1'b0);
        add(18, 1'b0, 3'b001, 1'b0);
        add(21, 1'b0, 3'b001, 1'b0);
        add(22, 1'b0, 3'b011, 1'b0);
        add(25, 1'b0, 3'b011, 1'b0);
        add(26, 1'b0, 3'b111, 1'b0);
        add(27, 1'b0, 3'b111, 1'b1);
        add(30, 1'b0, 3'b111, 1'b1);
`ifdef RST_SEQ_SWRST_FILT_EN
        add(35, 1'b1, 3'b111, 1'b1);
        add(36, 1'b0, 3'b111, 1'b1);
        add(40, 1'b1, 3'b111, 1'b1);
        add(41, 1'b1, 3'b000, 1'b0);
        add(56, 1'b0, 3'b000, 1'b0);
        add(57, 1'b0, 3'b001, 1'b0);
        add(61, 1'b0, 3'b011, 1'b0);
        add(65, 1'b0, 3'b111, 1'b0);
        add(66, 1'b0, 3'b111, 1'b1);
`else
        add(40, 1'b1, 3'b000, 1'b0);
        add(55, 1'b0, 3'b000, 1'b0);
        add(56, 1'b0, 3'b001, 1'b0);
        add(59, 1'b0, 3'b001, 1'b0);
        add(60, 1'b0, 3'b011, 1'b0);
        add(64, 1'b0, 3'b111, 1'b0);
        add(65, 1'b0, 3'b111, 1'b1);
`endif
        p_hi = vecs.size() - 1;

        // Run up to edge 20 ahead of the asynchronous abort.
        a_lo = vecs.size();
        add(18, 1'b0, 3'b001, 1'b0);
        add(20, 1'b0, 3'b001, 1'b0);
        a_hi = vecs.size() - 1;

        // Re-release after the abort repeats power-on timing.
        r_lo = vecs.size();
        add(17, 1'b0, 3'b000, 1'b0);
        add(18, 1'b0, 3'b001, 1'b0);
        add(22, 1'b0, 3'b011, 1'b0);
        add(26, 1'b0, 3'b111, 1'b0);
        add(27, 1'b0, 3'b111, 1'b1);
        r_hi = vecs.size() - 1;

        // Software reset while in REL; reference edge is 23.
        b_lo = vecs.size();
        add(18, 1'b0, 3'b001, 1'b0);
        add(21, 1'b0, 3'b001, 1'b0);
`ifdef RST_SEQ_SWRST_FILT_EN
        add(22, 1'b1, 3'b011, 1'b0);
`else
        add(22, 1'b0, 3'b011, 1'b0);
`endif
        add(23, 1'b1, 3'b000, 1'b0);
        add(38, 1'b0, 3'b000, 1'b0);
        add(39, 1'b0, 3'b001, 1'b0);
        add(42, 1'b0, 3'b001, 1'b0);
        add(43, 1'b0, 3'b011, 1'b0);
        add(47, 1'b0, 3'b111, 1'b0);
        add(48, 1'b0, 3'b111, 1'b1);
        b_hi = vecs.size() - 1;

        // SW_RST high through reset and IDLE has no effect on the timing.
        c_lo = vecs.size();
        add(1,  1'b1, 3'b000, 1'b0);
        add(2,  1'b1, 3'b000, 1'b0);
        add(3,  1'b1, 3'b000, 1'b0);
        add(17, 1'b0, 3'b000, 1'b0);
        add(18, 1'b0, 3'b001, 1'b0);
        add(27, 1'b0, 3'b111, 1'b1);
        c_hi = vecs.size() - 1;

        apply_reset(1'b0);
        run_vecs(p_lo, p_hi);

        apply_reset(1'b0);
        run_vecs(a_lo, a_hi);
        #3;
        RST = 1'b0;
        #1;
        check("abort_no_clock", 3'b000, 1'b0);
        apply_reset(1'b0);
        run_vecs(r_lo, r_hi);

        apply_reset(1'b0);
        run_vecs(b_lo, b_hi);

        apply_reset(1'b1);
        run_vecs(c_lo, c_hi);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
